echo_detector: RTL and testbench

Downstream consumer of the filter bank's moving-average output. Once per sample strobe it compares the smoothed envelope against a hysteresis threshold pair and measures time-of-flight in samples from a `start` pulse to the first qualified echo. It also tracks the echo's peak amplitude and reports a registered result with `valid`, or reports a timeout. It shares the filter bank's sample strobe and sits between the filter bank and the register/bus interface.

---
 rtl/echo_det_pkg.sv | 21 ++
 rtl/echo_detector.sv | 186 ++++++++++++++++++
 tb/tb_echo_detector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/echo_det_pkg.sv
// Shared types and constants for the echo detector: FSM state encoding
// and the tof value reported when a measurement times out.
package echo_det_pkg;

    // Default widths used by the detector and by anything that reads its results.
    localparam int DEF_N  = 16;
    localparam int DEF_CW = 24;

    // tof value reported when no echo was found before the timeout.
    localparam logic [DEF_CW-1:0] TOF_SENTINEL = {DEF_CW{1'b1}};

    // Measurement phases.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BLANK  = 3'd1,
        ST_ARM    = 3'd2,
        ST_LISTEN = 3'd3,
        ST_PEAK   = 3'd4
    } echo_state_e;

endpackage : echo_det_pkg

// File: rtl/echo_detector.sv
// Echo detector: on each sample strobe compares the smoothed envelope with a
// hysteresis threshold pair, measures time-of-flight from start to the first
// qualified echo, tracks the echo peak and reports valid or timeout.
module echo_detector
    import echo_det_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic          start,
    input  logic [N-1:0]  y_maf,
    input  logic [N-1:0]  thr_hi,
    input  logic [N-1:0]  thr_lo,
    input  logic [CW-1:0] blank_len,
    input  logic [CW-1:0] timeout,
    output logic [CW-1:0] tof,
    output logic [N-1:0]  peak,
    output logic          valid,
    output logic          timeout_flag,
    output logic          busy
);

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] TOF_TMO  = {CW{1'b1}};
    localparam logic [CW-1:0] CW_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CW_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   CNT_STEP = {{CW{1'b0}}, 1'b1};

    echo_state_e   state_r,  state_s;
    logic [CW-1:0] cnt_r,    cnt_s;
    logic [N-1:0]  thr_hi_r, thr_hi_s;
    logic [N-1:0]  thr_lo_r, thr_lo_s;
    logic [CW-1:0] blank_r,  blank_s;
    logic [CW-1:0] tmo_r,    tmo_s;
    logic [CW-1:0] tof_r,    tof_s;
    logic [N-1:0]  peak_r,   peak_s;
    logic          valid_r,  valid_s;
    logic          tflag_r,  tflag_s;
    logic          busy_r,   busy_s;

    // cnt+1 kept one bit wider so the end-of-blank and timeout compares
    // stay correct even when the counter has saturated.
    logic [CW:0]   cnt_inc_s;
    logic [CW-1:0] tmo_eff_s;
    logic          below_lo_s;
    logic          at_hi_s;
    logic          tmo_hit_s;
    logic          tmo_zone_s;

    // Next-state, counter, parameter latch and result logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        thr_hi_s = thr_hi_r;
        thr_lo_s = thr_lo_r;
        blank_s  = blank_r;
        tmo_s    = tmo_r;
        tof_s    = tof_r;
        peak_s   = peak_r;
        valid_s  = valid_r;
        tflag_s  = tflag_r;

        cnt_inc_s  = {1'b0, cnt_r} + CNT_STEP;
        tmo_eff_s  = (tmo_r == CW_ZERO) ? CW_ONE : tmo_r;
        below_lo_s = (y_maf < thr_lo_r);
        at_hi_s    = (y_maf >= thr_hi_r);
        tmo_hit_s  = (cnt_inc_s >= {1'b0, tmo_eff_s});
        tmo_zone_s = (state_r == ST_ARM) || (state_r == ST_LISTEN) || (state_r == ST_PEAK);

        if (start) begin
            // A start always wins, including over a coincident strobe.
            thr_hi_s = thr_hi;
            thr_lo_s = thr_lo;
            blank_s  = blank_len;
            tmo_s    = timeout;
            cnt_s    = CW_ZERO;
            tof_s    = CW_ZERO;
            peak_s   = {N{1'b0}};
            valid_s  = 1'b0;
            tflag_s  = 1'b0;
            state_s  = (blank_len == CW_ZERO) ? ST_ARM : ST_BLANK;
        end else if (sample_en && (state_r != ST_IDLE)) begin
            case (state_r)
                ST_BLANK: begin
                    if (cnt_inc_s >= {1'b0, blank_r}) begin
                        state_s = ST_ARM;
                    end else begin
                        state_s = ST_BLANK;
                    end
                end
                ST_ARM: begin
                    // Wait for the transmit ring-down to fall below release level.
                    if (below_lo_s) begin
                        state_s = ST_LISTEN;
                    end else begin
                        state_s = ST_ARM;
                    end
                end
                ST_LISTEN: begin
                    if (at_hi_s) begin
                        tof_s   = cnt_r;
                        peak_s  = y_maf;
                        state_s = ST_PEAK;
                    end else begin
                        state_s = ST_LISTEN;
                    end
                end
                ST_PEAK: begin
                    // The releasing sample is not part of the echo.
                    if (below_lo_s) begin
                        valid_s = 1'b1;
                        state_s = ST_IDLE;
                    end else if (y_maf > peak_r) begin
                        peak_s  = y_maf;
                    end else begin
                        peak_s  = peak_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase

            // Timeout is judged on the post-action state: an echo detected
            // on the final sample still reports valid rather than a timeout.
            if (tmo_zone_s && tmo_hit_s) begin
                if (state_s == ST_PEAK) begin
                    valid_s = 1'b1;
                end else if (state_s != ST_IDLE) begin
                    tflag_s = 1'b1;
                    tof_s   = TOF_TMO;
                end else begin
                    valid_s = valid_s;
                end
                state_s = ST_IDLE;
            end else begin
                state_s = state_s;
            end

            cnt_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_inc_s[CW-1:0];
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State, counter, latched parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CW_ZERO;
            thr_hi_r <= {N{1'b0}};
            thr_lo_r <= {N{1'b0}};
            blank_r  <= CW_ZERO;
            tmo_r    <= CW_ZERO;
            tof_r    <= CW_ZERO;
            peak_r   <= {N{1'b0}};
            valid_r  <= 1'b0;
            tflag_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            thr_hi_r <= thr_hi_s;
            thr_lo_r <= thr_lo_s;
            blank_r  <= blank_s;
            tmo_r    <= tmo_s;
            tof_r    <= tof_s;
            peak_r   <= peak_s;
            valid_r  <= valid_s;
            tflag_r  <= tflag_s;
            busy_r   <= busy_s;
        end
    end

    assign tof          = tof_r;
    assign peak         = peak_r;
    assign valid        = valid_r;
    assign timeout_flag = tflag_r;
    assign busy         = busy_r;

endmodule : echo_detector

// File: tb/tb_echo_detector.sv
// Self-checking bench for echo_detector: directed scenarios plus randomized
// measurements scored against a sample-array reference model.
module tb_echo_detector;
    import echo_det_pkg::*;

    localparam int N  = 16;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en;
    logic          start;
    logic [N-1:0]  y_maf;
    logic [N-1:0]  thr_hi;
    logic [N-1:0]  thr_lo;
    logic [CW-1:0] blank_len;
    logic [CW-1:0] timeout;
    logic [CW-1:0] tof;
    logic [N-1:0]  peak;
    logic          valid;
    logic          timeout_flag;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int ys[128];

    int e_tof, e_peak, e_valid, e_tf, e_end;

    echo_detector #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .start(start),
        .y_maf(y_maf), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .blank_len(blank_len), .timeout(timeout),
        .tof(tof), .peak(peak), .valid(valid),
        .timeout_flag(timeout_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: scan the sample list with the measurement rules directly.
    function automatic void model(input int blank, input int tmo, input int hi, input int lo,
                                  output int m_tof, output int m_peak, output int m_valid,
                                  output int m_tf, output int m_end);
        int teff, last, a, h;
        teff = (tmo == 0) ? 1 : tmo;
        last = (teff - 1 > blank) ? teff - 1 : blank;
        a = -1; h = -1;
        m_tof = int'(TOF_SENTINEL); m_peak = 0; m_valid = 0; m_tf = 1; m_end = last;
        for (int i = blank; i <= last; i++) begin
            if (ys[i] < lo) begin a = i; break; end
        end
        if (a >= 0) begin
            for (int i = a + 1; i <= last; i++) begin
                if (ys[i] >= hi) begin h = i; break; end
            end
        end
        if (h >= 0) begin
            m_tof = h; m_peak = ys[h]; m_valid = 1; m_tf = 0;
            for (int j = h + 1; j <= last; j++) begin
                if (ys[j] < lo) begin m_end = j; break; end
                if (ys[j] > m_peak) m_peak = ys[j];
            end
        end
    endfunction

    task automatic do_start(input int blank, input int tmo, input int hi, input int lo,
                            input bit with_sample, input int y);
        if (with_sample) repeat (16) @(negedge clk);
        else @(negedge clk);
        thr_hi = N'(hi); thr_lo = N'(lo);
        blank_len = CW'(blank); timeout = CW'(tmo);
        start = 1'b1; sample_en = with_sample; y_maf = N'(y);
        @(negedge clk);
        start = 1'b0; sample_en = 1'b0;
        thr_hi = N'($urandom); thr_lo = N'($urandom);
        blank_len = CW'($urandom_range(0, 9)); timeout = CW'($urandom_range(0, 9));
    endtask

    task automatic do_sample(input int y);
        repeat (16) @(negedge clk);
        y_maf = N'(y); sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    task automatic check_result(input string tag);
        check_eq({tag, ".tof"},   32'(tof),          32'(e_tof));
        check_eq({tag, ".peak"},  32'(peak),         32'(e_peak));
        check_eq({tag, ".valid"}, 32'(valid),        32'(e_valid));
        check_eq({tag, ".tflag"}, 32'(timeout_flag), 32'(e_tf));
        check_eq({tag, ".busy"},  32'(busy),         32'd0);
    endtask

    // Full measurement from ys[], then one ignored strobe to confirm hold.
    task automatic run_meas(input string tag, input int blank, input int tmo,
                            input int hi, input int lo);
        model(blank, tmo, hi, lo, e_tof, e_peak, e_valid, e_tf, e_end);
        do_start(blank, tmo, hi, lo, 1'b0, 0);
        check_eq({tag, ".busy_start"}, 32'(busy), 32'd1);
        check_eq({tag, ".valid_clr"},  32'(valid), 32'd0);
        for (int i = 0; i <= e_end; i++) begin
            if (i == e_end) check_eq({tag, ".busy_pre"}, 32'(busy), 32'd1);
            do_sample(ys[i]);
        end
        check_result(tag);
        do_sample(int'($urandom_range(0, 3000)));
        check_result({tag, ".hold"});
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; start = 1'b0; y_maf = '0;
        thr_hi = '0; thr_lo = '0; blank_len = '0; timeout = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst.tof",   32'(tof),          32'd0);
        check_eq("rst.peak",  32'(peak),         32'd0);
        check_eq("rst.valid", 32'(valid),        32'd0);
        check_eq("rst.tflag", 32'(timeout_flag), 32'd0);
        check_eq("rst.busy",  32'(busy),         32'd0);

        // Basic echo with blanking of the ring-down.
        for (int i = 0; i < 128; i++) ys[i] = 100;
        for (int i = 0; i < 4; i++) ys[i] = 5000;
        ys[10] = 1200; ys[11] = 1800; ys[12] = 900; ys[13] = 150;
        run_meas("echo", 4, 100, 1000, 200);
        check_eq("echo.tof_const",  32'(tof),  32'd10);
        check_eq("echo.peak_const", 32'(peak), 32'd1800);

        // Never re-arms: timeout from ARM.
        for (int i = 0; i < 128; i++) ys[i] = 300;
        for (int i = 0; i < 4; i++) ys[i] = 5000;
        run_meas("tmo_arm", 4, 20, 1000, 200);
        check_eq("tmo_arm.tof_const", 32'(tof), 32'hFF_FFFF);

        // Echo that never releases: timeout from PEAK reports valid.
        for (int i = 0; i < 128; i++) ys[i] = 100;
        for (int i = 0; i < 4; i++) ys[i] = 5000;
        ys[15] = 1100; ys[16] = 1500; ys[17] = 1300; ys[18] = 1700; ys[19] = 1200;
        run_meas("tmo_peak", 4, 20, 1000, 200);
        check_eq("tmo_peak.peak_const", 32'(peak), 32'd1700);

        // Restart mid-PEAK with a coincident strobe.
        do_start(4, 20, 1000, 200, 1'b0, 0);
        for (int i = 0; i <= 16; i++) do_sample(ys[i]);
        check_eq("restart.busy_peak", 32'(busy), 32'd1);
        for (int i = 0; i < 128; i++) ys[i] = 100;
        ys[0] = 50; ys[1] = 1100; ys[2] = 1300; ys[3] = 100;
        model(0, 50, 1000, 200, e_tof, e_peak, e_valid, e_tf, e_end);
        do_start(0, 50, 1000, 200, 1'b1, 5000);
        check_eq("restart.valid", 32'(valid), 32'd0);
        check_eq("restart.busy",  32'(busy),  32'd1);
        check_eq("restart.tof",   32'(tof),   32'd0);
        check_eq("restart.peak",  32'(peak),  32'd0);
        for (int i = 0; i <= e_end; i++) do_sample(ys[i]);
        check_result("restart");
        check_eq("restart.tof_const", 32'(tof), 32'd1);

        // Reset during LISTEN, then a fresh measurement with no blanking.
        do_start(0, 50, 1000, 200, 1'b0, 0);
        do_sample(100);
        do_sample(300);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("rst2.tof",   32'(tof),          32'd0);
        check_eq("rst2.peak",  32'(peak),         32'd0);
        check_eq("rst2.valid", 32'(valid),        32'd0);
        check_eq("rst2.tflag", 32'(timeout_flag), 32'd0);
        check_eq("rst2.busy",  32'(busy),         32'd0);
        for (int i = 0; i < 128; i++) ys[i] = 100;
        ys[0] = 0; ys[1] = 1500;
        run_meas("post_rst", 0, 50, 1000, 200);
        check_eq("post_rst.tof_const", 32'(tof), 32'd1);

        // Randomized measurements.
        for (int t = 0; t < 30; t++) begin
            int lo, hi;
            lo = int'($urandom_range(100, 600));
            hi = lo + int'($urandom_range(0, 900));
            for (int i = 0; i < 128; i++) ys[i] = int'($urandom_range(0, 2000));
            run_meas("rand", int'($urandom_range(0, 6)), int'($urandom_range(0, 40)), hi, lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_echo_detector
